// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the CPU run controller
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        HC_NONE       = 3'd0,
        HC_SENTINEL   = 3'd1,
        HC_BREAKPOINT = 3'd2,
        HC_USER_STOP  = 3'd3,
        HC_WATCHDOG   = 3'd4,
        HC_STEP_DONE  = 3'd5
    } halt_cause_t;

    // ROM default-case word; marks end of program and is never executed
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h7FFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/halt sequencer for the single-cycle CPU
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter int          WDOG_LIMIT = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             restart,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      instr,
    input  logic [31:0]      current_pc,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam int              WD_W    = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    run_state_t      state_q, state_d;
    halt_cause_t     cause_q, cause_d;
    logic            bp_skip_q;
    logic            skip_set;
    logic [WD_W-1:0] wdog_q;
    logic [31:0]     prev_pc_q;

    logic sentinel_hit, bp_hit, active, pc_same, wdog_fire;

    assign sentinel_hit = (instr == HALT_INSTR);
    assign bp_hit       = bp_en && (current_pc == bp_addr) && !bp_skip_q;
    assign active       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cpu_en       = active && !sentinel_hit && !bp_hit && !stop;
    assign pc_same      = (current_pc == prev_pc_q);
    assign wdog_fire    = cpu_en && (state_q == ST_RUN) && pc_same && (wdog_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        skip_set = 1'b0;
        if (restart) begin
            state_d = ST_IDLE;
            cause_d = HC_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stop) begin
                        state_d = ST_HALTED;
                        cause_d = HC_USER_STOP;
                    end else if (step) begin
                        state_d = ST_STEP;
                    end else if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (stop) begin
                        state_d = ST_HALTED;
                        cause_d = HC_USER_STOP;
                    end else if (sentinel_hit) begin
                        state_d = ST_HALTED;
                        cause_d = HC_SENTINEL;
                    end else if (bp_hit) begin
                        state_d  = ST_HALTED;
                        cause_d  = HC_BREAKPOINT;
                        skip_set = 1'b1;
                    end else if (state_q == ST_STEP) begin
                        state_d = ST_HALTED;
                        cause_d = HC_STEP_DONE;
                    end else if (wdog_fire) begin
                        state_d = ST_HALTED;
                        cause_d = HC_WATCHDOG;
                    end
                end
                ST_HALTED: begin
                    // a sentinel halt is terminal until restart
                    if ((cause_q != HC_SENTINEL) && !stop) begin
                        if (step) begin
                            state_d = ST_STEP;
                            cause_d = HC_NONE;
                        end else if (start) begin
                            state_d = ST_RUN;
                            cause_d = HC_NONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= HC_NONE;
            bp_skip_q <= 1'b0;
            wdog_q    <= '0;
            prev_pc_q <= '0;
            cpu_rst   <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cpu_rst <= restart;
            if (restart) begin
                bp_skip_q <= 1'b0;
                wdog_q    <= '0;
                prev_pc_q <= '0;
            end else begin
                if (skip_set) begin
                    bp_skip_q <= 1'b1;
                end else if (cpu_en) begin
                    bp_skip_q <= 1'b0;
                end
                if (cpu_en) begin
                    prev_pc_q <= current_pc;
                end
                // counts consecutive enabled RUN cycles parked on one PC
                if ((state_q != ST_RUN) || (cpu_en && !pc_same)) begin
                    wdog_q <= '0;
                end else if (cpu_en) begin
                    wdog_q <= wdog_q + WD_ONE;
                end
            end
        end
    end

    assign state      = state_q;
    assign halt_cause = cause_q;

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr   (rst || restart),
        .inc   (active),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .clr   (rst || restart),
        .inc   (cpu_en),
        .count (retired_count)
    );

endmodule
